// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM state encoding, default
// geometry and requester identities.
package ram_arb_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } rid_t;

    function automatic rid_t other_id(input rid_t id);
        return (id == ID_A) ? ID_B : ID_A;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way requester pick. Round-robin on a last-granted pointer by default;
// RAMARB_FIXED_PRIO_EN makes A always win and removes the pointer.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    input  rid_t upd_id,
    output rid_t pick
);

`ifdef RAMARB_FIXED_PRIO_EN

    logic unused;
    assign unused = &{1'b0, clk, rst, req_b, upd, upd_id};

    assign pick = req_a ? ID_A : ID_B;

`else

    rid_t last;

    // Reset to B as last-granted so A is favoured first.
    always_ff @(posedge clk) begin
        if (rst)
            last <= ID_B;
        else if (upd)
            last <= upd_id;
    end

    always_comb begin
        pick = ID_A;
        if (req_a && req_b)
            pick = other_id(last);
        else if (req_b)
            pick = ID_B;
    end

`endif

endmodule

// File: rtl/ram_arb2.sv
// Arbitrates two requesters onto one single-port RAM with a registered read.
// Optional RAMARB_FIXED_PRIO_EN selects fixed A-first priority.
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    state_t        state;
    rid_t          id;
    rid_t          pick;
    logic          we_q;
    logic [DW-1:0] hold_a;
    logic [DW-1:0] hold_b;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .req_b  (req_b),
        .upd    (gnt_a | gnt_b),
        .upd_id (id),
        .pick   (pick)
    );

    always_comb begin
        sel_we    = we_a;
        sel_addr  = addr_a;
        sel_wdata = wdata_a;
        if (pick == ID_B) begin
            sel_we    = we_b;
            sel_addr  = addr_b;
            sel_wdata = wdata_b;
        end
    end

    // Strobes are loaded on the IDLE->SERVE edge so they are live for exactly
    // the SERVE cycle; ram_addr/ram_din double as the latched operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id        <= ID_A;
            we_q      <= 1'b0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            hold_a    <= '0;
            hold_b    <= '0;
        end else begin
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            if (rvalid_a)
                hold_a <= ram_dout;
            if (rvalid_b)
                hold_b <= ram_dout;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        id        <= pick;
                        we_q      <= sel_we;
                        ram_addr  <= sel_addr;
                        ram_din   <= sel_wdata;
                        ram_write <= sel_we;
                        ram_read  <= ~sel_we;
                        gnt_a     <= (pick == ID_A);
                        gnt_b     <= (pick == ID_B);
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        rvalid_a <= (id == ID_A);
                        rvalid_b <= (id == ID_B);
                        state    <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM data arrives during RESP; pass it through then, hold it afterwards.
    assign rdata_a = rvalid_a ? ram_dout : hold_a;
    assign rdata_b = rvalid_b ? ram_dout : hold_b;

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a behavioural registered-read RAM.
module tb_ram_arb2;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ram_read, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int checks   = 0;
    int failures = 0;

    ram_arb2 #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM: location i resets to 0x10+i, read data registered.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= DW'(8'h10 + i);
            ram_dout <= '0;
        end else begin
            if (ram_write) mem[ram_addr] <= ram_din;
            if (ram_read)  ram_dout <= mem[ram_addr];
        end
    end

    // {gnt_a,gnt_b,rvalid_a,rvalid_b,ram_read,ram_write,ram_addr,ram_din,rdata_a,rdata_b}
    typedef logic [33:0] obs_t;

    typedef struct {
        logic          ra, wa;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          rb, wb;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        obs_t          exp;
    } vec_t;

    function automatic obs_t observe();
        return {gnt_a, gnt_b, rvalid_a, rvalid_b, ram_read, ram_write,
                ram_addr, ram_din, rdata_a, rdata_b};
    endfunction

    function automatic obs_t mk(input logic ga, gb, va, vb, rd, wr,
                                input logic [3:0] ad, input logic [7:0] dn, rda, rdb);
        return {ga, gb, va, vb, rd, wr, ad, dn, rda, rdb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    vec_t tbl [13];
    int   gnt_ids [$];

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("reset_outputs", 64'(observe()), 64'(obs_t'(0)));
        rst = 1'b0;

        //            A:req we addr data     B:req we addr data    expected after the edge
        tbl[0]  = '{1,1,3,8'hA5, 0,0,0,0, mk(1,0,0,0,0,1,3,8'hA5,8'h00,8'h00)};
        tbl[1]  = '{0,0,0,8'h00, 0,0,0,0, mk(0,0,0,0,0,0,3,8'hA5,8'h00,8'h00)};
        tbl[2]  = '{1,0,3,8'h00, 0,0,0,0, mk(1,0,0,0,1,0,3,8'h00,8'h00,8'h00)};
        tbl[3]  = '{0,0,0,8'h00, 0,0,0,0, mk(0,0,1,0,0,0,3,8'h00,8'hA5,8'h00)};
        tbl[4]  = '{0,0,0,8'h00, 0,0,0,0, mk(0,0,0,0,0,0,3,8'h00,8'hA5,8'h00)};
        tbl[5]  = '{0,0,0,8'h00, 1,1,7,8'h3C, mk(0,1,0,0,0,1,7,8'h3C,8'hA5,8'h00)};
        tbl[6]  = '{0,0,0,8'h00, 0,0,0,0, mk(0,0,0,0,0,0,7,8'h3C,8'hA5,8'h00)};
        tbl[7]  = '{0,0,0,8'h00, 1,0,7,8'h00, mk(0,1,0,0,1,0,7,8'h00,8'hA5,8'h00)};
        tbl[8]  = '{0,0,0,8'h00, 0,0,0,0, mk(0,0,0,1,0,0,7,8'h00,8'hA5,8'h3C)};
        tbl[9]  = '{0,0,0,8'h00, 1,0,4,8'h00, mk(0,0,0,0,0,0,7,8'h00,8'hA5,8'h3C)};
        tbl[10] = '{0,0,0,8'h00, 1,0,4,8'h00, mk(0,1,0,0,1,0,4,8'h00,8'hA5,8'h3C)};
        tbl[11] = '{0,0,0,8'h00, 0,0,0,0, mk(0,0,0,1,0,0,4,8'h00,8'hA5,8'h14)};
        tbl[12] = '{0,0,0,8'h00, 0,0,0,0, mk(0,0,0,0,0,0,4,8'h00,8'hA5,8'h14)};

        for (int i = 0; i < 13; i++) begin
            req_a = tbl[i].ra; we_a = tbl[i].wa; addr_a = tbl[i].aa; wdata_a = tbl[i].da;
            req_b = tbl[i].rb; we_b = tbl[i].wb; addr_b = tbl[i].ab; wdata_b = tbl[i].db;
            step();
            check($sformatf("vec%0d", i), 64'(observe()), 64'(tbl[i].exp));
        end

        // Both requesters hold read requests: grant order after reset.
        do_reset();
        req_a = 1; we_a = 0; addr_a = 4'd1;
        req_b = 1; we_b = 0; addr_b = 4'd2;
        for (int c = 0; c < 12; c++) begin
            step();
            if (gnt_a && gnt_b) check("dual_gnt", 64'd1, 64'd0);
            if (gnt_a) gnt_ids.push_back(0);
            if (gnt_b) gnt_ids.push_back(1);
        end
        idle_inputs();
        check("rr_gnt_count", 64'(gnt_ids.size()), 64'd4);
        foreach (gnt_ids[k]) begin
`ifdef RAMARB_FIXED_PRIO_EN
            check($sformatf("prio_gnt%0d", k), 64'(gnt_ids[k]), 64'd0);
`else
            check($sformatf("rr_gnt%0d", k), 64'(gnt_ids[k]), 64'(k % 2));
`endif
        end
        step(); step(); step();

        // Reset while B's read is in SERVE abandons it.
        do_reset();
        req_b = 1; we_b = 0; addr_b = 4'd5;
        step();
        check("rstserve_gnt_b", 64'(gnt_b), 64'd1);
        rst = 1'b1;
        req_b = 0;
        step();
        check("rstserve_outputs", 64'(observe()), 64'(obs_t'(0)));
        rst = 1'b0;
        step();
        check("rstserve_no_rvalid1", 64'({rvalid_b, gnt_b}), 64'd0);
        step();
        check("rstserve_no_rvalid2", 64'({rvalid_b, gnt_b}), 64'd0);

        // B's address changes after selection; the in-flight read keeps addr 5.
        req_b = 1; we_b = 0; addr_b = 4'd5;
        step();
        req_b = 0; addr_b = 4'd9;
        check("late_addr_ram_addr", 64'({gnt_b, ram_read, ram_addr}), 64'({1'b1, 1'b1, 4'd5}));
        step();
        check("late_addr_rdata", 64'({rvalid_b, rdata_b}), 64'({1'b1, 8'h15}));
        step();
        check("late_addr_idle", 64'({rvalid_b, gnt_b, ram_read}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
